ialu_mdu: RTL

IALU_MDU -- requirements
Module: ialu_mdu

---
 rtl/ialu_mdu_pkg.sv | 39 +++
 rtl/ialu_mdu_step.sv | 37 +++
 rtl/ialu_mdu.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/ialu_mdu_pkg.sv
// Shared types and command-class helpers for the iterative multiply/divide unit.
package ialu_mdu_pkg;

  typedef enum logic [2:0] {
    CMD_MUL    = 3'd0,
    CMD_MULH   = 3'd1,
    CMD_MULHSU = 3'd2,
    CMD_MULHU  = 3'd3,
    CMD_DIV    = 3'd4,
    CMD_DIVU   = 3'd5,
    CMD_REM    = 3'd6,
    CMD_REMU   = 3'd7
  } mdu_cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_CORR = 2'd2,
    ST_DONE = 2'd3
  } mdu_state_e;

  function automatic logic is_mul(input mdu_cmd_e c);
    return (c == CMD_MUL) || (c == CMD_MULH) || (c == CMD_MULHSU) || (c == CMD_MULHU);
  endfunction

  function automatic logic is_rem(input mdu_cmd_e c);
    return (c == CMD_REM) || (c == CMD_REMU);
  endfunction

  // MUL treats both operands as unsigned: the low product half is sign-agnostic.
  function automatic logic is_signed_op1(input mdu_cmd_e c);
    return (c == CMD_MULH) || (c == CMD_MULHSU) || (c == CMD_DIV) || (c == CMD_REM);
  endfunction

  function automatic logic is_signed_op2(input mdu_cmd_e c);
    return (c == CMD_MULH) || (c == CMD_DIV) || (c == CMD_REM);
  endfunction

endpackage

// File: rtl/ialu_mdu_step.sv
// One combinational iteration: shift-add for multiply, restoring trial-subtract for divide.
module ialu_mdu_step
  import ialu_mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            is_mul_i,
  input  logic [XLEN-1:0] hi_i,
  input  logic [XLEN-1:0] lo_i,
  input  logic [XLEN-1:0] opb_i,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  logic [XLEN:0] sum;
  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  // Multiply: {hi,lo} holds partial product and remaining multiplier bits.
  // Divide: hi is the partial remainder, lo shifts dividend out and quotient in.
  always_comb begin
    sum     = {1'b0, hi_i} + (lo_i[0] ? {1'b0, opb_i} : '0);
    shifted = {hi_i, lo_i[XLEN-1]};
    diff    = shifted - {1'b0, opb_i};
    if (is_mul_i) begin
      hi_o = sum[XLEN:1];
      lo_o = {sum[0], lo_i[XLEN-1:1]};
    end else if (!diff[XLEN]) begin
      hi_o = diff[XLEN-1:0];
      lo_o = {lo_i[XLEN-2:0], 1'b1};
    end else begin
      hi_o = shifted[XLEN-1:0];
      lo_o = {lo_i[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/ialu_mdu.sv
// RV32M/RV64M multiply-divide unit: IDLE/CALC/CORR/DONE iterative datapath.
// Define IALU_MDU_FAST_MUL_EN for a single-cycle combinational multiplier.
module ialu_mdu
  import ialu_mdu_pkg::*;
#(
  parameter int SCR1_XLEN           = 32,
  parameter int SCR1_IALU_CMD_WIDTH = 3
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           ialu_rvm_cmd_vd_i,
  input  logic [SCR1_IALU_CMD_WIDTH-1:0] ialu_cmd_i,
  input  logic [SCR1_XLEN-1:0]           ialu_main_op1_i,
  input  logic [SCR1_XLEN-1:0]           ialu_main_op2_i,
  output logic [SCR1_XLEN-1:0]           ialu_main_res_o,
  output logic                           ialu_rvm_res_rdy_o,
  output logic                           ialu_busy_o,
  output mdu_state_e                     dbg_state_o
);

  localparam int XW2 = 2 * SCR1_XLEN;
  localparam int CW  = $clog2(SCR1_XLEN);
  localparam logic [SCR1_XLEN-1:0] ALL_ONES = '1;
  localparam logic [SCR1_XLEN-1:0] MOST_NEG = {1'b1, {(SCR1_XLEN-1){1'b0}}};
  localparam logic [CW-1:0]        CNT_LAST = CW'(SCR1_XLEN - 1);

  mdu_state_e           state_q, state_d;
  mdu_cmd_e             cmd_q, cmd_d, cmd_in;
  logic                 neg_q, neg_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [SCR1_XLEN-1:0] hi_q, hi_d, lo_q, lo_d, opb_q, opb_d, res_q, res_d;
  logic [SCR1_XLEN-1:0] step_hi, step_lo;
  logic [SCR1_XLEN-1:0] abs1, abs2;
  logic                 sgn1, sgn2, neg_in, div_zero, div_ovf;
`ifdef IALU_MDU_FAST_MUL_EN
  logic [XW2-1:0]       fast_prod;
`endif

  // hl packs {high product, low product} or {remainder, quotient}.
  function automatic logic [SCR1_XLEN-1:0] fix_result(input mdu_cmd_e c, input logic neg,
                                                      input logic [XW2-1:0] hl);
    logic [XW2-1:0]       nhl;
    logic [SCR1_XLEN-1:0] r;
    nhl = neg ? -hl : hl;
    case (c)
      CMD_MUL:                        r = hl[SCR1_XLEN-1:0];
      CMD_MULH, CMD_MULHSU, CMD_MULHU: r = nhl[XW2-1:SCR1_XLEN];
      CMD_DIV, CMD_DIVU:              r = neg ? -hl[SCR1_XLEN-1:0] : hl[SCR1_XLEN-1:0];
      default:                        r = neg ? -hl[XW2-1:SCR1_XLEN] : hl[XW2-1:SCR1_XLEN];
    endcase
    return r;
  endfunction

  ialu_mdu_step #(.XLEN(SCR1_XLEN)) u_step (
    .is_mul_i (is_mul(cmd_q)),
    .hi_i     (hi_q),
    .lo_i     (lo_q),
    .opb_i    (opb_q),
    .hi_o     (step_hi),
    .lo_o     (step_lo)
  );

  always_comb begin
    cmd_in   = mdu_cmd_e'(ialu_cmd_i[2:0]);
    sgn1     = is_signed_op1(cmd_in) & ialu_main_op1_i[SCR1_XLEN-1];
    sgn2     = is_signed_op2(cmd_in) & ialu_main_op2_i[SCR1_XLEN-1];
    abs1     = sgn1 ? -ialu_main_op1_i : ialu_main_op1_i;
    abs2     = sgn2 ? -ialu_main_op2_i : ialu_main_op2_i;
    neg_in   = is_rem(cmd_in) ? sgn1 : (sgn1 ^ sgn2);
    div_zero = !is_mul(cmd_in) && (ialu_main_op2_i == '0);
    div_ovf  = is_signed_op1(cmd_in) && !is_mul(cmd_in) &&
               (ialu_main_op1_i == MOST_NEG) && (ialu_main_op2_i == ALL_ONES);
  end

`ifdef IALU_MDU_FAST_MUL_EN
  assign fast_prod = XW2'(abs1) * XW2'(abs2);
`endif

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    neg_d   = neg_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    opb_d   = opb_q;
    res_d   = res_q;
    case (state_q)
      ST_IDLE: begin
        if (ialu_rvm_cmd_vd_i) begin
          cmd_d = cmd_in;
          neg_d = neg_in;
          cnt_d = '0;
          hi_d  = '0;
          lo_d  = is_mul(cmd_in) ? abs2 : abs1;
          opb_d = is_mul(cmd_in) ? abs1 : abs2;
          if (div_zero) begin
            res_d   = is_rem(cmd_in) ? ialu_main_op1_i : ALL_ONES;
            state_d = ST_DONE;
          end else if (div_ovf) begin
            res_d   = is_rem(cmd_in) ? '0 : ialu_main_op1_i;
            state_d = ST_DONE;
`ifdef IALU_MDU_FAST_MUL_EN
          end else if (is_mul(cmd_in)) begin
            res_d   = fix_result(cmd_in, neg_in, fast_prod);
            state_d = ST_DONE;
`endif
          end else begin
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        if (!ialu_rvm_cmd_vd_i) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          hi_d    = '0;
          lo_d    = '0;
          opb_d   = '0;
        end else begin
          hi_d  = step_hi;
          lo_d  = step_lo;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) state_d = ST_CORR;
        end
      end
      ST_CORR: begin
        if (!ialu_rvm_cmd_vd_i) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          hi_d    = '0;
          lo_d    = '0;
          opb_d   = '0;
        end else begin
          res_d   = fix_result(cmd_q, neg_q, {hi_q, lo_q});
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cmd_q   <= CMD_MUL;
      neg_q   <= 1'b0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      opb_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      neg_q   <= neg_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
    end
  end

  // Handshake: issuer holds cmd_vd high until the one-cycle res_rdy pulse
  // (or drops it to abort); result is only meaningful while res_rdy is high.
  assign ialu_rvm_res_rdy_o = (state_q == ST_DONE);
  assign ialu_main_res_o    = ialu_rvm_res_rdy_o ? res_q : '0;
  assign ialu_busy_o        = (state_q != ST_IDLE);
  assign dbg_state_o        = state_q;

endmodule
